// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: sequential restoring divider, one quotient bit per clock, valid/ready on both sides
// Ports: clk, rst_n (async active-low); in_valid/in_ready with dividend[DW]/divisor[VW];
//        out_valid/out_ready with quotient[DW], remainder[VW], div_by_zero.
// Macro DIV_EARLY_EXIT_EN: zero divisor or dividend < divisor finishes after a single RUN edge.
module seq_restoring_divider #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(DW + 1);
  state_t state, state_nxt;
  logic [CW-1:0] count;
  logic [VW-1:0] div;
  logic [DW-1:0] q;
  // a restored partial remainder is always below the divisor, so VW bits hold it
  logic [VW-1:0] prem;
  logic [VW:0] shifted;
  logic dz, ge, last, early, start;
  assign shifted = {prem, q[DW-1]};
  assign ge = shifted >= {1'b0, div};
  assign last = count == CW'(DW - 1);
  assign start = state == IDLE && in_valid;
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign quotient = q;
  assign remainder = prem;
  assign div_by_zero = dz;
`ifdef DIV_EARLY_EXIT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) early <= 1'b0;
    else if (start) early <= divisor == '0 || dividend < DW'(divisor);
`else
  assign early = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    if (start) state_nxt = RUN;
    if (state == RUN && (last || early)) state_nxt = DONE;
    if (state == DONE && out_ready) state_nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      div <= '0;
      q <= '0;
      prem <= '0;
      dz <= 1'b0;
    end else if (start) begin
      count <= '0;
      div <= divisor;
      q <= dividend;
      prem <= '0;
      dz <= 1'b0;
    end else if (state == RUN) begin
      count <= count + 1'b1;
      if (early) begin
        q <= div == '0 ? '1 : '0;
        prem <= div == '0 ? '0 : q[VW-1:0];
        dz <= div == '0;
      end else if (last && div == '0) begin
        q <= '1;
        prem <= '0;
        dz <= 1'b1;
      end else begin
        prem <= VW'(ge ? shifted - {1'b0, div} : shifted);
        q <= {q[DW-2:0], ge};
      end
    end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// tb_seq_restoring_divider: randomized and directed checks of seq_restoring_divider against plain arithmetic
module tb_seq_restoring_divider;
  localparam int DW = 8;
  localparam int VW = 4;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, div_by_zero;
  logic [DW-1:0] dividend = '0, quotient;
  logic [VW-1:0] divisor = '0, remainder;
  int n_chk = 0, n_fail = 0;

  seq_restoring_divider #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [DW-1:0] a, input logic [VW-1:0] b, input int hold, input bit busy);
    logic [DW-1:0] eq;
    logic [VW-1:0] er;
    logic ez;
    int lat, edges;
    ez = b == 0;
    eq = ez ? {DW{1'b1}} : a / b;
    er = ez ? '0 : VW'(a % b);
    lat = DW + 1;
`ifdef DIV_EARLY_EXIT_EN
    if (ez || a < b) lat = 2;
`endif
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    dividend = a;
    divisor = b;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    edges = 1;
    if (busy) begin
      dividend = 100;
      divisor = 3;
      check("busy_in_ready", in_ready, 0);
    end
    while (!out_valid && edges < 40) begin
      in_valid = busy && edges == 3;
      @(posedge clk);
      #1;
      edges++;
    end
    in_valid = 0;
    check($sformatf("latency %0d/%0d", a, b), edges, lat);
    for (int i = 0; i <= hold; i++) begin
      check($sformatf("quotient %0d/%0d", a, b), quotient, eq);
      check($sformatf("remainder %0d/%0d", a, b), remainder, er);
      check($sformatf("dbz %0d/%0d", a, b), div_by_zero, ez);
      if (hold > 0) begin
        check("hold_out_valid", out_valid, 1);
        check("hold_in_ready", in_ready, 0);
      end
      if (i < hold) begin
        @(posedge clk);
        #1;
      end
    end
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    logic seen;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst_n = 1;
    run_op(200, 7, 0, 0);
    run_op(255, 15, 0, 0);
    run_op(0, 5, 0, 0);
    run_op(15, 1, 0, 0);
    run_op(9, 0, 0, 0);
    run_op(3, 9, 0, 0);
    run_op(200, 7, 5, 0);
    run_op(200, 7, 0, 1);
    @(negedge clk);
    dividend = 200;
    divisor = 7;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    check("midrun_rst_out_valid", out_valid, 0);
    check("midrun_rst_in_ready", in_ready, 1);
    check("midrun_rst_quotient", quotient, 0);
    check("midrun_rst_remainder", remainder, 0);
    check("midrun_rst_dbz", div_by_zero, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen |= out_valid;
    end
    check("midrun_rst_no_result", seen, 0);
    run_op(50, 6, 0, 0);
    for (int a = 0; a < (1 << DW); a++)
      for (int b = 0; b < (1 << VW); b++)
        run_op(DW'(a), VW'(b), int'($urandom_range(0, 1)), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
